// File: rtl/jtag_tap_controller_pkg.sv
// Shared TAP definitions: state encodings, instruction opcodes, DR selection
// and the 1149.1 state-transition function.
package jtag_tap_controller_pkg;

  localparam int IR_WIDTH_DEF = 4;

  // Standard 1149.1 TAP state encoding
  typedef enum logic [3:0] {
    ST_EXIT2_DR   = 4'h0,
    ST_EXIT1_DR   = 4'h1,
    ST_SHIFT_DR   = 4'h2,
    ST_PAUSE_DR   = 4'h3,
    ST_SELECT_IR  = 4'h4,
    ST_UPDATE_DR  = 4'h5,
    ST_CAPTURE_DR = 4'h6,
    ST_SELECT_DR  = 4'h7,
    ST_EXIT2_IR   = 4'h8,
    ST_EXIT1_IR   = 4'h9,
    ST_SHIFT_IR   = 4'hA,
    ST_PAUSE_IR   = 4'hB,
    ST_RTI        = 4'hC,
    ST_UPDATE_IR  = 4'hD,
    ST_CAPTURE_IR = 4'hE,
    ST_TLR        = 4'hF
  } tap_state_e;

  // Opcodes at the default 4-bit IR width
  localparam logic [3:0] OP_EXTEST         = 4'b0000;
  localparam logic [3:0] OP_SAMPLE_PRELOAD = 4'b0001;
  localparam logic [3:0] OP_IDCODE         = 4'b0010;
  localparam logic [3:0] OP_BYPASS         = 4'b1111;

  // Which data register sits between TDI and TDO
  typedef enum logic [1:0] {
    DR_BSR = 2'd0,
    DR_ID  = 2'd1,
    DR_BYP = 2'd2
  } dr_sel_e;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    tap_state_e n;
    n = ST_TLR;
    case (s)
      ST_TLR:        n = tms ? ST_TLR       : ST_RTI;
      ST_RTI:        n = tms ? ST_SELECT_DR : ST_RTI;
      ST_SELECT_DR:  n = tms ? ST_SELECT_IR : ST_CAPTURE_DR;
      ST_CAPTURE_DR: n = tms ? ST_EXIT1_DR  : ST_SHIFT_DR;
      ST_SHIFT_DR:   n = tms ? ST_EXIT1_DR  : ST_SHIFT_DR;
      ST_EXIT1_DR:   n = tms ? ST_UPDATE_DR : ST_PAUSE_DR;
      ST_PAUSE_DR:   n = tms ? ST_EXIT2_DR  : ST_PAUSE_DR;
      ST_EXIT2_DR:   n = tms ? ST_UPDATE_DR : ST_SHIFT_DR;
      ST_UPDATE_DR:  n = tms ? ST_SELECT_DR : ST_RTI;
      ST_SELECT_IR:  n = tms ? ST_TLR       : ST_CAPTURE_IR;
      ST_CAPTURE_IR: n = tms ? ST_EXIT1_IR  : ST_SHIFT_IR;
      ST_SHIFT_IR:   n = tms ? ST_EXIT1_IR  : ST_SHIFT_IR;
      ST_EXIT1_IR:   n = tms ? ST_UPDATE_IR : ST_PAUSE_IR;
      ST_PAUSE_IR:   n = tms ? ST_EXIT2_IR  : ST_PAUSE_IR;
      ST_EXIT2_IR:   n = tms ? ST_UPDATE_IR : ST_SHIFT_IR;
      ST_UPDATE_IR:  n = tms ? ST_SELECT_DR : ST_RTI;
      default:       n = ST_TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_tap_controller_fsm.sv
// TAP state machine: 16 states advanced by TMS on each TCK rising edge.
module jtag_tap_controller_fsm
  import jtag_tap_controller_pkg::*;
(
  input  logic       TCK,
  input  logic       TRST,
  input  logic       TMS,
  output tap_state_e tap_state
);

  tap_state_e state_q;

  // TRST wins over TMS; otherwise follow the standard transition table
  always_ff @(posedge TCK) begin
    if (TRST) state_q <= ST_TLR;
    else      state_q <= tap_next(state_q, TMS);
  end

  assign tap_state = state_q;

endmodule

// File: rtl/jtag_tap_controller.sv
// TAP controller for the adder wrapper: IR, bypass and ID registers, chain
// control decode and the TDO mux. Everything is clocked on TCK rising edge.
module jtag_tap_controller
  import jtag_tap_controller_pkg::*;
#(
  parameter int          IR_WIDTH   = IR_WIDTH_DEF,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input  logic       TCK,
  input  logic       TRST,
  input  logic       TMS,
  input  logic       TDI,
  input  logic       bsr_tdo,
  output logic       TDO,
  output logic       tdo_en,
  output logic       ShiftDR,
  output logic       ClockDR,
  output logic       UpdateDR,
  output logic       Mode,
  output logic [3:0] tap_state
);

  localparam logic [IR_WIDTH-1:0] IR_EXTEST  = IR_WIDTH'(OP_EXTEST);
  localparam logic [IR_WIDTH-1:0] IR_SAMPLE  = IR_WIDTH'(OP_SAMPLE_PRELOAD);
  localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(OP_IDCODE);
  localparam logic [IR_WIDTH-1:0] IR_BYPASS  = IR_WIDTH'(OP_BYPASS);
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

  tap_state_e           state;
  dr_sel_e              dr_sel;
  logic                 chain_sel;
  logic [IR_WIDTH-1:0]  ir_q, ir_d;    // active instruction
  logic [IR_WIDTH-1:0]  irs_q, irs_d;  // IR shift stage
  logic                 byp_q, byp_d;
  logic [31:0]          id_q, id_d;

  jtag_tap_controller_fsm u_fsm (
    .TCK       (TCK),
    .TRST      (TRST),
    .TMS       (TMS),
    .tap_state (state)
  );

  // Instruction decode: unknown opcodes fall through to bypass
  always_comb begin
    dr_sel = DR_BYP;
    case (ir_q)
      IR_EXTEST, IR_SAMPLE: dr_sel = DR_BSR;
      IR_IDCODE:            dr_sel = DR_ID;
      IR_BYPASS:            dr_sel = DR_BYP;
      default:              dr_sel = DR_BYP;
    endcase
  end

  assign chain_sel = (dr_sel == DR_BSR);

  // Next values of the IR, bypass and ID registers from the current state
  always_comb begin
    irs_d = irs_q;
    ir_d  = ir_q;
    byp_d = byp_q;
    id_d  = id_q;
    case (state)
      ST_CAPTURE_IR: irs_d = IR_CAPTURE;
      ST_SHIFT_IR:   irs_d = {TDI, irs_q[IR_WIDTH-1:1]};
      ST_UPDATE_IR:  ir_d  = irs_q;
      ST_CAPTURE_DR: begin
        byp_d = 1'b0;
        id_d  = IDCODE_VAL;
      end
      ST_SHIFT_DR: begin
        byp_d = TDI;
        id_d  = {TDI, id_q[31:1]};
      end
      default: ;
    endcase
    // TLR is only reached from TLR or SELECT_IR with TMS=1; load IDCODE on that edge
    if (TMS && (state == ST_TLR || state == ST_SELECT_IR)) ir_d = IR_IDCODE;
  end

  // Register update with synchronous reset to the TLR defaults
  always_ff @(posedge TCK) begin
    if (TRST) begin
      ir_q  <= IR_IDCODE;
      irs_q <= '0;
      byp_q <= 1'b0;
      id_q  <= IDCODE_VAL;
    end else begin
      ir_q  <= ir_d;
      irs_q <= irs_d;
      byp_q <= byp_d;
      id_q  <= id_d;
    end
  end

  // TDO selects register state only, so it is stable between TCK edges
  always_comb begin
    TDO = 1'b0;
    case (state)
      ST_SHIFT_IR: TDO = irs_q[0];
      ST_SHIFT_DR: begin
        case (dr_sel)
          DR_BSR:  TDO = bsr_tdo;
          DR_ID:   TDO = id_q[0];
          default: TDO = byp_q;
        endcase
      end
      default: TDO = 1'b0;
    endcase
  end

  // Chain controls decode the registered state and IR only
  assign tdo_en    = (state == ST_SHIFT_DR) || (state == ST_SHIFT_IR);
  assign ShiftDR   = (state == ST_SHIFT_DR);
  assign ClockDR   = chain_sel && ((state == ST_CAPTURE_DR) || (state == ST_SHIFT_DR));
  assign UpdateDR  = chain_sel && (state == ST_UPDATE_DR);
  assign Mode      = (ir_q == IR_EXTEST);
  assign tap_state = state;

endmodule
